// File: rtl/palette_fade_lut.sv
// palette_fade_lut: banked, run-time-writable colour palette with a
// frame-synchronous brightness fader and a 2-cycle registered read path.
// Palette words are packed {red, green, blue}, red in the top bits.
module palette_fade_lut #(
  parameter int IDX_W           = 4,
  parameter int CH_W            = 4,
  parameter int NUM_BANKS       = 4,
  parameter int FADE_STEPS      = 16,
  parameter int FRAMES_PER_STEP = 2,
  localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int LVL_W          = $clog2(FADE_STEPS) + 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pix_valid,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic [IDX_W-1:0]    index,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                rgb_valid,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                frame_start,
  input  logic                fade_out_go,
  input  logic                fade_in_go,
  output logic                fade_busy,
  output logic                fade_done,
  output logic [LVL_W-1:0]    level
);

  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** IDX_W);
  localparam int LVL_SH = $clog2(FADE_STEPS);
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {
    ST_FULL     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_DARK     = 2'd2,
    ST_FADE_IN  = 2'd3
  } fade_state_t;

  // Scale one channel by the brightness level; FADE_STEPS maps to unity.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [LVL_W-1:0] lvl);
    logic [CH_W+LVL_W-1:0] prod;
    prod = (CH_W+LVL_W)'(c) * (CH_W+LVL_W)'(lvl);
    return CH_W'(prod >> LVL_SH);
  endfunction

  logic [3*CH_W-1:0] mem_r [0:DEPTH-1];
  logic [3*CH_W-1:0] rd_data_r;
  logic              rd_oob_s, wr_oob_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              valid1_r, oob1_r;

  fade_state_t       state_r, state_s;
  logic [LVL_W-1:0]  level_r, level_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              done_s, busy_s, go_out_s, go_in_s;

  // Bank range checks, done one bit wider so a power-of-two bank count never wraps.
  always_comb begin
    rd_oob_s = ({1'b0, bank_sel} >= (BANK_W+1)'(NUM_BANKS));
    wr_oob_s = ({1'b0, wr_bank}  >= (BANK_W+1)'(NUM_BANKS));
    if (rd_oob_s) begin
      rd_addr_s = '0;
    end else begin
      rd_addr_s = {bank_sel, index};
    end
  end

  // Palette RAM: write port plus registered read (old data on collision); not reset.
  always_ff @(posedge Clk) begin
    if (wr_en && !wr_oob_s) begin
      mem_r[{wr_bank, wr_index}] <= wr_rgb;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Stage 1 control: request valid and out-of-range bank flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid1_r <= 1'b0;
      oob1_r   <= 1'b0;
    end else begin
      valid1_r <= pix_valid;
      oob1_r   <= rd_oob_s;
    end
  end

  // Stage 2: brightness scaling and registered colour outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= valid1_r;
      if (oob1_r) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= scale_ch(rd_data_r[3*CH_W-1:2*CH_W], level_r);
        green <= scale_ch(rd_data_r[2*CH_W-1:CH_W], level_r);
        blue  <= scale_ch(rd_data_r[CH_W-1:0], level_r);
      end
    end
  end

  // Fade FSM next state: go pulses only act in their entry state and only alone.
  always_comb begin
    state_s  = state_r;
    level_s  = level_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    go_out_s = fade_out_go && !fade_in_go;
    go_in_s  = fade_in_go && !fade_out_go;
    case (state_r)
      ST_FULL: begin
        if (go_out_s) begin
          state_s = ST_FADE_OUT;
          cnt_s   = '0;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_FADE_OUT: begin
        if (frame_start) begin
          if (cnt_r == CNT_W'(FRAMES_PER_STEP - 1)) begin
            cnt_s   = '0;
            level_s = level_r - LVL_W'(1);
            if (level_r == LVL_W'(1)) begin
              state_s = ST_DARK;
              done_s  = 1'b1;
            end else begin
              state_s = ST_FADE_OUT;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DARK: begin
        if (go_in_s) begin
          state_s = ST_FADE_IN;
          cnt_s   = '0;
        end else begin
          state_s = ST_DARK;
        end
      end
      ST_FADE_IN: begin
        if (frame_start) begin
          if (cnt_r == CNT_W'(FRAMES_PER_STEP - 1)) begin
            cnt_s   = '0;
            level_s = level_r + LVL_W'(1);
            if (level_r == LVL_W'(FADE_STEPS - 1)) begin
              state_s = ST_FULL;
              done_s  = 1'b1;
            end else begin
              state_s = ST_FADE_IN;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_FULL;
        level_s = LVL_W'(FADE_STEPS);
        cnt_s   = '0;
      end
    endcase
    busy_s = (state_s == ST_FADE_OUT) || (state_s == ST_FADE_IN);
  end

  // Fade FSM registers, including registered busy/done flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_FULL;
      level_r   <= LVL_W'(FADE_STEPS);
      cnt_r     <= '0;
      fade_busy <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      level_r   <= level_s;
      cnt_r     <= cnt_s;
      fade_busy <= busy_s;
      fade_done <= done_s;
    end
  end

  assign level = level_r;

endmodule

// File: tb/tb_palette_fade_lut.sv
// Directed bench for palette_fade_lut (NUM_BANKS=3, other parameters default).
module tb_palette_fade_lut;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [1:0]  bank_sel;
  logic [3:0]  index;
  logic [3:0]  red, green, blue;
  logic        rgb_valid;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        frame_start, fade_out_go, fade_in_go;
  logic        fade_busy, fade_done;
  logic [4:0]  level;

  int total = 0;
  int bad   = 0;
  int dcnt  = 0;

  palette_fade_lut #(.NUM_BANKS(3)) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .bank_sel(bank_sel),
    .index(index), .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .frame_start(frame_start), .fade_out_go(fade_out_go), .fade_in_go(fade_in_go),
    .fade_busy(fade_busy), .fade_done(fade_done), .level(level)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] b, input logic [3:0] i,
                    input logic [11:0] exp);
    pix_valid = 1'b1; bank_sel = b; index = i;
    tick();
    pix_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 16'(rgb_valid), 16'd1);
    chk(tag, 16'({red, green, blue}), 16'(exp));
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    if (fade_done) dcnt++;
    frame_start = 1'b0;
    tick();
    if (fade_done) dcnt++;
  endtask

  initial begin
    Reset = 1'b1; pix_valid = 1'b0; bank_sel = 2'd0; index = 4'd0;
    wr_en = 1'b0; wr_bank = 2'd0; wr_index = 4'd0; wr_rgb = 12'h000;
    frame_start = 1'b0; fade_out_go = 1'b0; fade_in_go = 1'b0;
    tick();
    tick();
    chk("rst_valid", 16'(rgb_valid), 16'd0);
    chk("rst_rgb",   16'({red, green, blue}), 16'h000);
    chk("rst_level", 16'(level), 16'd16);
    chk("rst_busy",  16'(fade_busy), 16'd0);
    chk("rst_done",  16'(fade_done), 16'd0);
    Reset = 1'b0;
    tick();

    // Basic write / read
    wr(2'd1, 4'd5, 12'hD1E);
    wr(2'd1, 4'd6, 12'hABC);
    wr(2'd0, 4'd9, 12'h377);
    wr(2'd0, 4'd1, 12'hF84);
    wr(2'd2, 4'd3, 12'hFFF);
    rd("rd_b1i5", 2'd1, 4'd5, 12'hD1E);

    // Same-cycle write and read of one address returns the old word
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd9; wr_rgb = 12'h4CF;
    pix_valid = 1'b1; bank_sel = 2'd0; index = 4'd9;
    tick();
    wr_en = 1'b0; pix_valid = 1'b0;
    tick();
    chk("coll_old", 16'({red, green, blue}), 16'h377);
    rd("coll_new", 2'd0, 4'd9, 12'h4CF);

    // Back-to-back requests, one result per cycle
    pix_valid = 1'b1; bank_sel = 2'd1; index = 4'd5;
    tick();
    bank_sel = 2'd1; index = 4'd6;
    tick();
    chk("b2b_0", 16'({rgb_valid, red, green, blue}), 16'h1D1E);
    bank_sel = 2'd0; index = 4'd9;
    tick();
    chk("b2b_1", 16'({rgb_valid, red, green, blue}), 16'h1ABC);
    pix_valid = 1'b0;
    tick();
    chk("b2b_2", 16'({rgb_valid, red, green, blue}), 16'h14CF);
    tick();
    chk("b2b_idle", 16'(rgb_valid), 16'd0);

    // Out-of-range bank reads zero; write to bank 3 is dropped
    rd("oob_rd", 2'd3, 4'd3, 12'h000);
    wr(2'd3, 4'd3, 12'h123);
    rd("oob_wr_b2", 2'd2, 4'd3, 12'hFFF);
    rd("oob_wr_b0", 2'd0, 4'd3 + 4'd6, 12'h4CF);

    // Ignored go pulses in FULL
    fade_in_go = 1'b1;
    tick();
    fade_in_go = 1'b0;
    tick();
    chk("ign_in_busy", 16'(fade_busy), 16'd0);
    chk("ign_in_lvl",  16'(level), 16'd16);
    fade_in_go = 1'b1; fade_out_go = 1'b1;
    tick();
    fade_in_go = 1'b0; fade_out_go = 1'b0;
    tick();
    chk("ign_both_busy", 16'(fade_busy), 16'd0);

    // Fade out: one level per two frames
    fade_out_go = 1'b1;
    tick();
    fade_out_go = 1'b0;
    chk("fo_busy", 16'(fade_busy), 16'd1);
    dcnt = 0;
    for (int k = 1; k <= 32; k++) begin
      frame();
      chk("fo_level", 16'(level), 16'(16 - k / 2));
      if (k == 16) rd("fo_lvl8", 2'd0, 4'd1, 12'h742);
    end
    chk("fo_done_cnt", 16'(dcnt), 16'd1);
    chk("fo_idle", 16'(fade_busy), 16'd0);
    rd("dark_fff", 2'd2, 4'd3, 12'h000);
    fade_out_go = 1'b1;
    tick();
    fade_out_go = 1'b0;
    tick();
    chk("ign_out_dark", 16'({fade_busy, level}), 16'h0000);

    // Fade in
    fade_in_go = 1'b1;
    tick();
    fade_in_go = 1'b0;
    chk("fi_busy", 16'(fade_busy), 16'd1);
    dcnt = 0;
    for (int k = 1; k <= 32; k++) begin
      frame();
      chk("fi_level", 16'(level), 16'(k / 2));
      if (k == 10) rd("fi_lvl5", 2'd2, 4'd3, 12'h444);
    end
    chk("fi_done_cnt", 16'(dcnt), 16'd1);
    chk("fi_idle", 16'(fade_busy), 16'd0);
    rd("full_fff", 2'd2, 4'd3, 12'hFFF);

    // Reset mid fade-out at level 5
    fade_out_go = 1'b1;
    tick();
    fade_out_go = 1'b0;
    for (int k = 1; k <= 22; k++) frame();
    chk("mid_lvl5", 16'(level), 16'd5);
    pix_valid = 1'b1; bank_sel = 2'd1; index = 4'd5;
    tick();
    pix_valid = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mr_level", 16'(level), 16'd16);
    chk("mr_busy",  16'(fade_busy), 16'd0);
    chk("mr_valid", 16'(rgb_valid), 16'd0);
    chk("mr_rgb",   16'({red, green, blue}), 16'h000);
    frame();
    chk("mr_frame_lvl", 16'(level), 16'd16);
    rd("mr_keep", 2'd1, 4'd5, 12'hD1E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
